// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the ID/EX pipeline controller: words, register
// indices, the decoded control bundle and the stage-advance FSM states.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       memrd;
        logic       memwr;
        logic       memtoreg;
    } ctrl_t;

    typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, HALTED = 2'd2} pipe_state_t;

    localparam word_t NOP_INSTR = 32'h0;
endpackage

// File: rtl/id_ex_pipe_ctrl_if.sv
// Stall/advance interface between the fetch/decode side (master) and the
// IF/ID + ID/EX register controller (slave).
interface id_ex_pipe_ctrl_if #(parameter int CNT_W = 32);
    import cpu_types_pkg::*;

    logic             ihit, dhit, mem_req, IDdopause, ex_flush;
    word_t            if_instr, if_npc;
    regbits_t         id_rs, id_rt, id_wsel;
    logic             id_RegWr, id_halt;
    ctrl_t            id_ctrl;

    word_t            ifid_instr, ifid_npc;
    logic             ifid_valid;
    regbits_t         EXwsel, EXrs, EXrt;
    logic             EXRegWr;
    ctrl_t            idex_ctrl;
    logic             idex_valid;
    logic             pc_en, halt;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  ihit, dhit, mem_req, IDdopause, ex_flush, if_instr, if_npc,
               id_rs, id_rt, id_wsel, id_RegWr, id_halt, id_ctrl,
        output ifid_instr, ifid_npc, ifid_valid, EXwsel, EXrs, EXrt, EXRegWr,
               idex_ctrl, idex_valid, pc_en, halt, stall_cnt
    );

    modport master (
        output ihit, dhit, mem_req, IDdopause, ex_flush, if_instr, if_npc,
               id_rs, id_rt, id_wsel, id_RegWr, id_halt, id_ctrl,
        input  ifid_instr, ifid_npc, ifid_valid, EXwsel, EXrs, EXrt, EXRegWr,
               idex_ctrl, idex_valid, pc_en, halt, stall_cnt
    );
endinterface

// File: rtl/pipe_reg.sv
// Pipeline data register: clears to all-zero on reset or bubble, loads on en,
// otherwise holds.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         en,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         q <= '0;
        else if (bubble) q <= '0;
        else if (en)     q <= d;
    end
endmodule

// File: rtl/id_ex_pipe_ctrl.sv
// IF/ID and ID/EX stage-advance controller: decides load/hold/bubble per cycle,
// tracks data-memory waits and halt, and counts RAW-hazard stall cycles.
module id_ex_pipe_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic              CLK,
    input logic              RST,
    id_ex_pipe_ctrl_if.slave bus
);
    localparam int IFID_W = 1 + 2 * $bits(word_t);
    localparam int IDEX_W = 1 + 3 * $bits(regbits_t) + 1 + $bits(ctrl_t);

    pipe_state_t       r_state;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_dwait, w_active, w_flush, w_stall, w_halt_set;
    logic              w_ifid_en, w_ifid_bubble, w_idex_bubble;
    logic              w_ifid_valid, w_ex_regwr;
    logic [IFID_W-1:0] w_ifid_d, w_ifid_q;
    logic [IDEX_W-1:0] w_idex_d, w_idex_q;

    // A data-memory wait freezes everything, including a pending flush.
    assign w_dwait  = bus.mem_req & ~bus.dhit;
    assign w_active = (r_state != HALTED) & ~w_dwait;
    assign w_flush  = w_active & bus.ex_flush;
    assign w_stall  = w_active & ~bus.ex_flush & bus.IDdopause & bus.ihit;

    assign w_ifid_en     = w_active & ~w_stall;
    assign w_ifid_bubble = w_flush | (w_ifid_en & ~bus.ihit);
    // Advancing an empty IF/ID is a bubble too, so stray decode ctrl never leaks.
    assign w_idex_bubble = w_flush | w_stall | (w_active & ~w_ifid_valid);
    assign w_halt_set    = w_active & ~bus.ex_flush & ~w_stall & w_ifid_valid & bus.id_halt;

    assign w_ifid_d = {1'b1, bus.if_instr, bus.if_npc};
    assign w_idex_d = {1'b1, bus.id_rs, bus.id_rt, bus.id_wsel, bus.id_RegWr, bus.id_ctrl};

    pipe_reg #(.W(IFID_W)) u_ifid (
        .CLK(CLK), .RST(RST), .en(w_ifid_en), .bubble(w_ifid_bubble),
        .d(w_ifid_d), .q(w_ifid_q)
    );

    pipe_reg #(.W(IDEX_W)) u_idex (
        .CLK(CLK), .RST(RST), .en(w_active), .bubble(w_idex_bubble),
        .d(w_idex_d), .q(w_idex_q)
    );

    assign {w_ifid_valid, bus.ifid_instr, bus.ifid_npc} = w_ifid_q;
    assign {bus.idex_valid, bus.EXrs, bus.EXrt, bus.EXwsel, w_ex_regwr, bus.idex_ctrl} = w_idex_q;

    assign bus.ifid_valid = w_ifid_valid;
    assign bus.EXRegWr    = w_ex_regwr & bus.idex_valid;
    assign bus.pc_en      = ~RST & w_active & (bus.ex_flush | (bus.ihit & ~bus.IDdopause));
    assign bus.halt       = (r_state == HALTED);
    assign bus.stall_cnt  = r_stall_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                      r_state <= RUN;
        else if (r_state == HALTED)   r_state <= HALTED;
        else if (w_dwait)             r_state <= DWAIT;
        else if (w_halt_set)          r_state <= HALTED;
        else                          r_state <= RUN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
endmodule

// File: tb/tb_id_ex_pipe_ctrl.sv
// Bench for id_ex_pipe_ctrl: cycle-level reference model feeds a scoreboard of
// expected register/pc_en snapshots, plus directed checks from the test plan.
module tb_id_ex_pipe_ctrl;
    import cpu_types_pkg::*;

    typedef struct packed {
        word_t    fi;
        word_t    fn;
        logic     fv;
        regbits_t rs;
        regbits_t rt;
        regbits_t ws;
        logic     rw;
        ctrl_t    ctrl;
        logic     ev;
        logic     halt;
        logic [31:0] cnt;
        logic     pc;
    } snap_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    id_ex_pipe_ctrl_if #(.CNT_W(32)) bus ();
    id_ex_pipe_ctrl_if #(.CNT_W(2))  sbus ();

    id_ex_pipe_ctrl #(.CNT_W(32)) dut   (.CLK(CLK), .RST(RST), .bus(bus.slave));
    id_ex_pipe_ctrl #(.CNT_W(2))  dut_s (.CLK(CLK), .RST(RST), .bus(sbus.slave));

    // Decode stage stand-in: fields of whatever sits in IF/ID.
    assign bus.id_rs    = bus.ifid_instr[25:21];
    assign bus.id_rt    = bus.ifid_instr[20:16];
    assign bus.id_wsel  = bus.ifid_instr[20:16];
    assign bus.id_RegWr = (bus.ifid_instr != 32'h0);
    assign bus.id_halt  = (bus.ifid_instr[31:26] == 6'h3f);
    assign bus.id_ctrl  = ctrl_t'(bus.ifid_instr[31:24]);

    assign sbus.id_rs    = '0;
    assign sbus.id_rt    = '0;
    assign sbus.id_wsel  = '0;
    assign sbus.id_RegWr = 1'b0;
    assign sbus.id_halt  = 1'b0;
    assign sbus.id_ctrl  = '0;
    assign sbus.if_instr = '0;
    assign sbus.if_npc   = '0;

    int checks = 0;
    int errors = 0;

    snap_t exp_q[$];
    snap_t obs_q[$];
    logic  last_pc;
    word_t npc_ctr;

    // Reference model state
    word_t    m_fi, m_fn;
    logic     m_fv, m_ev, m_rw, m_halt;
    regbits_t m_rs, m_rt, m_ws;
    ctrl_t    m_ctrl;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_fi = '0; m_fn = '0; m_fv = 0;
        m_ev = 0; m_rw = 0; m_rs = '0; m_rt = '0; m_ws = '0; m_ctrl = '0;
        m_halt = 0; m_cnt = '0;
    endtask

    task automatic clr_ifid(); m_fi = '0; m_fn = '0; m_fv = 0; endtask
    task automatic clr_ex();   m_ev = 0; m_rw = 0; m_rs = '0; m_rt = '0; m_ws = '0; m_ctrl = '0; endtask

    function automatic snap_t model_out(input logic pc);
        snap_t s;
        s.fi = m_fi; s.fn = m_fn; s.fv = m_fv;
        s.rs = m_rs; s.rt = m_rt; s.ws = m_ws; s.rw = m_rw & m_ev;
        s.ctrl = m_ctrl; s.ev = m_ev; s.halt = m_halt; s.cnt = m_cnt; s.pc = pc;
        return s;
    endfunction

    function automatic snap_t snap(input logic pc);
        snap_t s;
        s.fi = bus.ifid_instr; s.fn = bus.ifid_npc; s.fv = bus.ifid_valid;
        s.rs = bus.EXrs; s.rt = bus.EXrt; s.ws = bus.EXwsel; s.rw = bus.EXRegWr;
        s.ctrl = bus.idex_ctrl; s.ev = bus.idex_valid; s.halt = bus.halt;
        s.cnt = bus.stall_cnt; s.pc = pc;
        return s;
    endfunction

    // One clock of stimulus: drive, run the model, queue expected and observed.
    task automatic cycle(input logic ih, input word_t ins, input logic pause = 0,
                         input logic flush = 0, input logic mreq = 0, input logic dh = 0);
        logic pc;
        npc_ctr = npc_ctr + 32'd4;
        bus.ihit = ih; bus.if_instr = ins; bus.if_npc = npc_ctr;
        bus.IDdopause = pause; bus.ex_flush = flush; bus.mem_req = mreq; bus.dhit = dh;
        @(negedge CLK);
        last_pc = bus.pc_en;
        pc = 1'b0;
        if (!m_halt && !(mreq && !dh)) begin
            if (flush) begin
                clr_ifid(); clr_ex(); pc = 1'b1;
            end else if (pause && ih) begin
                clr_ex();
                if (m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 1;
            end else begin
                if (m_fv) begin
                    m_ev = 1; m_rs = m_fi[25:21]; m_rt = m_fi[20:16]; m_ws = m_fi[20:16];
                    m_rw = (m_fi != 32'h0); m_ctrl = ctrl_t'(m_fi[31:24]);
                    if (m_fi[31:26] == 6'h3f) m_halt = 1;
                end else clr_ex();
                if (ih) begin m_fv = 1; m_fi = ins; m_fn = npc_ctr; pc = 1'b1; end
                else clr_ifid();
            end
        end
        exp_q.push_back(model_out(pc));
        @(posedge CLK); #1;
        obs_q.push_back(snap(last_pc));
    endtask

    task automatic test_reset();
        snap_t o;
        #2;
        o = snap(bus.pc_en);
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_state: got %h want 0", o); end
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        snap_t e, o;
        cycle(1, 32'h20010005);
        checks++;
        if (bus.ifid_instr !== 32'h20010005) begin errors++; $display("FAIL stream_c1: ifid_instr got %h want 20010005", bus.ifid_instr); end
        cycle(1, 32'h20020007);
        checks++;
        if (bus.ifid_instr !== 32'h20020007) begin errors++; $display("FAIL stream_c2: ifid_instr got %h want 20020007", bus.ifid_instr); end
        checks++;
        if (bus.EXwsel !== 5'd1) begin errors++; $display("FAIL stream_exwsel: got %0d want 1", bus.EXwsel); end
        cycle(0, 32'h0);
        cycle(1, 32'h2003000b);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL stream_sb: got %h want %h", o, e); end
        end
    endtask

    task automatic test_stall();
        snap_t e, o;
        logic [31:0] c0;
        cycle(1, 32'h20010005);
        cycle(1, 32'h20020007);
        c0 = bus.stall_cnt;
        for (int i = 0; i < 2; i++) begin
            cycle(1, 32'h20030009, 1);
            checks++;
            if (bus.ifid_instr !== 32'h20020007 || bus.EXRegWr !== 1'b0 || last_pc !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: ifid %h regwr %b pc_en %b want 20020007/0/0", bus.ifid_instr, bus.EXRegWr, last_pc);
            end
        end
        checks++;
        if (bus.stall_cnt !== c0 + 32'd2) begin errors++; $display("FAIL stall_cnt: got %0d want %0d", bus.stall_cnt, c0 + 2); end
        cycle(1, 32'h20030009);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL stall_sb: got %h want %h", o, e); end
        end
    endtask

    task automatic test_dwait_flush();
        snap_t e, o;
        word_t held;
        cycle(1, 32'h20040001);
        cycle(1, 32'h20050002);
        held = bus.ifid_instr;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 32'h20060003, 0, 1, 1, 0);
            checks++;
            if (bus.ifid_instr !== held || bus.ifid_valid !== 1'b1 || bus.idex_valid !== 1'b1 || last_pc !== 1'b0) begin
                errors++;
                $display("FAIL dwait_freeze: ifid %h v %b/%b pc_en %b want %h v 1/1 pc 0", bus.ifid_instr, bus.ifid_valid, bus.idex_valid, last_pc, held);
            end
        end
        cycle(1, 32'h20060003, 0, 1, 1, 1);
        checks++;
        if (bus.ifid_valid !== 1'b0 || bus.idex_valid !== 1'b0 || last_pc !== 1'b1) begin
            errors++;
            $display("FAIL dhit_flush: valid %b/%b pc_en %b want 0/0/1", bus.ifid_valid, bus.idex_valid, last_pc);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL dwait_sb: got %h want %h", o, e); end
        end
    endtask

    task automatic test_flush_vs_pause();
        snap_t e, o;
        logic [31:0] c0;
        cycle(1, 32'h20070004);
        cycle(1, 32'h20080005);
        c0 = bus.stall_cnt;
        cycle(1, 32'h20090006, 1, 1);
        checks++;
        if (bus.stall_cnt !== c0 || bus.ifid_valid !== 1'b0 || bus.idex_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_pause: cnt %0d valid %b/%b want %0d 0/0", bus.stall_cnt, bus.ifid_valid, bus.idex_valid, c0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL flushpause_sb: got %h want %h", o, e); end
        end
    endtask

    task automatic test_random();
        snap_t e, o;
        word_t ins;
        for (int i = 0; i < 80; i++) begin
            ins = $urandom;
            if (ins[31:26] == 6'h3f) ins[31] = 1'b0;
            cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL random_sb: got %h want %h", o, e); end
        end
    endtask

    task automatic test_reset_dwait();
        snap_t o;
        cycle(1, 32'h200a0001);
        cycle(1, 32'h200b0002, 0, 0, 1, 0);
        cycle(1, 32'h200b0002, 0, 0, 1, 0);
        exp_q.delete(); obs_q.delete();
        #1 RST = 1'b1;
        #1;
        o = snap(bus.pc_en);
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_dwait: got %h want 0", o); end
        RST = 1'b0;
        bus.mem_req = 1'b0; bus.ihit = 1'b1; bus.IDdopause = 1'b0; bus.ex_flush = 1'b0;
        #1;
        checks++;
        if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL reset_run_pc: pc_en got %b want 1", bus.pc_en); end
        model_reset();
    endtask

    task automatic test_halt();
        snap_t e, o;
        word_t fi;
        cycle(1, 32'h20010005);
        cycle(1, 32'hfc000000);
        cycle(1, 32'h20030009);
        checks++;
        if (bus.halt !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", bus.halt); end
        fi = bus.ifid_instr;
        for (int i = 0; i < 10; i++) cycle(1, 32'h20100000 + i);
        checks++;
        if (bus.halt !== 1'b1 || bus.ifid_instr !== fi || last_pc !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold: halt %b ifid %h pc_en %b want 1 %h 0", bus.halt, bus.ifid_instr, last_pc, fi);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL halt_sb: got %h want %h", o, e); end
        end
        RST = 1'b1;
        #1;
        checks++;
        if (bus.halt !== 1'b0) begin errors++; $display("FAIL halt_reset: got %b want 0", bus.halt); end
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_saturate();
        logic [1:0] want;
        sbus.ihit = 1'b1; sbus.IDdopause = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge CLK); #1;
            want = (i > 3) ? 2'd3 : 2'(i);
            checks++;
            if (sbus.stall_cnt !== want) begin errors++; $display("FAIL saturate_%0d: got %0d want %0d", i, sbus.stall_cnt, want); end
        end
        sbus.ihit = 1'b0; sbus.IDdopause = 1'b0;
    endtask

    initial begin
        npc_ctr = '0;
        last_pc = 1'b0;
        bus.ihit = 0; bus.dhit = 0; bus.mem_req = 0; bus.IDdopause = 0; bus.ex_flush = 0;
        bus.if_instr = '0; bus.if_npc = '0;
        sbus.ihit = 0; sbus.dhit = 0; sbus.mem_req = 0; sbus.IDdopause = 0; sbus.ex_flush = 0;
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_dwait_flush();
        test_flush_vs_pause();
        test_random();
        test_reset_dwait();
        test_halt();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_ctrl.md
# id_ex_pipe_ctrl

Stage-advance controller and storage for the IF/ID and ID/EX pipeline registers of the 5-stage datapath. It consumes the hazard unit's ID stall request (`IDdopause`), `ihit`/`dhit` and the EX branch-flush, and decides per cycle whether each register loads, holds or takes a bubble. It also drives the ID/EX-side hazard-unit inputs (`EXwsel`, `EXRegWr`) and a saturating stall counter, so it is the responder end of the stall interface.

## Interface
- `CNT_W`, default 32, width of the stall-cycle counter.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `ihit`  in  1  instruction memory returned a valid word this cycle.
- `dhit`  in  1  data memory completed the access held in EX/MEM.
- `mem_req`  in  1  EX/MEM holds a load or store awaiting `dhit`.
- `IDdopause`  in  1  RAW-hazard stall request from the hazard unit.
- `ex_flush`  in  1  taken branch or jump resolved in EX.
- `if_instr`, `if_npc`  in  word_t  fetched instruction and PC+4.
- `id_rs`, `id_rt`, `id_wsel`  in  regbits_t  decoded fields of the ID instruction.
- `id_RegWr`, `id_halt`  in  1  decoded write-enable and halt opcode.
- `id_ctrl`  in  ctrl_t  remaining decoded control bundle.
- `ifid_instr`, `ifid_npc`  out  word_t  IF/ID register contents.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `EXwsel`  out  regbits_t  ID/EX destination register (to hazard unit).
- `EXRegWr`  out  1  ID/EX write-enable, forced 0 for bubbles (to hazard unit).
- `idex_ctrl`  out  ctrl_t  ID/EX control bundle, all-zero for bubbles.
- `idex_valid`  out  1  ID/EX holds a real instruction.
- `pc_en`  out  1  PC may advance this cycle.
- `halt`  out  1  sticky; the processor has halted.
- `stall_cnt`  out  CNT_W  count of cycles in which ID was stalled by `IDdopause`.

## Operation
- `dwait = mem_req & ~dhit`. States: RUN, DWAIT, HALTED.
- RUN, `dwait`=1: go DWAIT; both registers hold; `pc_en`=0.
- DWAIT: hold everything until `dhit`; on `dhit` return to RUN and apply the RUN rules in that same cycle.
- RUN, no `dwait`, priority order:
  - `ex_flush`: IF/ID and ID/EX both load bubbles (valid=0, instr=0, RegWr=0, wsel=0, ctrl=0); `pc_en`=1.
  - `IDdopause & ihit`: IF/ID holds; ID/EX loads a bubble; `pc_en`=0; `stall_cnt` increments.
  - `ihit`: IF/ID loads `if_instr`/`if_npc` with valid=1; ID/EX loads the ID fields with `idex_valid`=`ifid_valid`; `pc_en`=1.
  - `~ihit`: IF/ID loads a bubble; ID/EX advances from IF/ID as above; `pc_en`=0.
- Halt: when ID/EX loads a valid instruction with `id_halt`=1, go HALTED next cycle. HALTED freezes both registers, `pc_en`=0, `halt`=1, and is left only by `RST`. A flush in the loading cycle cancels the halt.
- `EXRegWr` = stored RegWr & `idex_valid`, so a bubble never creates a false hazard.
- `stall_cnt` saturates at all-ones and never wraps.

## Timing
- Reset (async): state RUN, all register outputs 0, `ifid_valid`=`idex_valid`=0, `halt`=0, `stall_cnt`=0. `pc_en` is combinational and evaluates to 0 while `RST` is high.
- `pc_en` is combinational from the current state and inputs; all register updates occur on the next edge.
- One-cycle latency IF -> IF/ID -> ID/EX. Each `IDdopause` cycle inserts exactly one bubble.
- Simultaneous `dwait` and `ex_flush`: `dwait` wins. The flush must be held by EX, and it is applied in the cycle `dhit` arrives.
- Simultaneous `ex_flush` and `IDdopause`: the flush wins and the stall counter does not increment.
- `RST` asserted in DWAIT or HALTED returns to RUN immediately.

## Structure
- In `cpu_types_pkg`: `ctrl_t` packed control struct, `pipe_state_t` enum {RUN, DWAIT, HALTED}, `NOP_INSTR` constant = 32'h0.
- One natural sub-module, `pipe_reg`: a parameterised data register with `en`, `bubble` and async `RST`, instantiated once for IF/ID and once for ID/EX. The FSM and stall counter live in the top module.

## Test plan
- Reset mid-DWAIT (`mem_req`=1, `dhit`=0, then pulse `RST`) -> all outputs 0 and state RUN on the same cycle, with no edge required.
- Steady stream with `ihit`=1, instrs 0x20010005, 0x20020007 -> appear on `ifid_instr` at cycles 1 and 2; `EXwsel`=1 at cycle 2.
- `IDdopause`=1 for 2 cycles with `ihit`=1 -> `ifid_instr` is held, two bubbles reach ID/EX (`EXRegWr`=0), `pc_en`=0 on both cycles, `stall_cnt`=2.
- `mem_req`=1, `dhit`=0 for 3 cycles, `ex_flush`=1 throughout -> everything frozen for 3 cycles; on the `dhit` cycle both registers go invalid.
- Halt opcode enters ID/EX -> `halt`=1 on the next cycle and stays high for 10 further cycles of `ihit`=1, with no register changes.
- Force `stall_cnt` to all-ones minus 1, then apply 3 stall cycles -> the counter reaches all-ones and holds there.
